// File: rtl/cla_nibble_sub.sv
// Serial subtractor: a - b as a + ~b + 1, one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Latency: out_valid rises NIB edges after the accepting edge; the next accept is possible NIB+2 edges later.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module cla_nibble_sub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb_n;   // subtrahend stored already inverted

   logic [CW+1:0]    lsb;
   logic [3:0]       an, bn, g, p, s;
   logic [4:0]       c;
   logic             last;

   assign lsb       = {cnt, 2'b00};
   assign last      = (cnt == CW'(NIB - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // One 4-bit lookahead slice over the current nibble, carry-in from the carry register
   always_comb begin
      an   = opa[lsb +: 4];
      bn   = opb_n[lsb +: 4];
      g    = an & bn;
      p    = an ^ bn;
      c    = '0;
      c[0] = cy;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s    = p ^ c[3:0];
   end

   // Control FSM plus operand, carry and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         cy     <= 1'b1;
         opa    <= '0;
         opb_n  <= '0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa   <= a;
                  opb_n <= ~b;
                  cy    <= 1'b1;   // the +1 of two's-complement negation
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               diff[lsb +: 4] <= s;
               cy             <= c[4];
               if (last) begin
                  borrow <= ~c[4];
                  ovf    <= c[3] ^ c[4];
                  cnt    <= '0;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_nibble_sub.sv
// Bench for cla_nibble_sub: directed corner cases with literal results plus randomized traffic.
// A scoreboard of accepted operations predicts handshake timing and results every cycle.
// out_ready stalls are randomized during the random phase.
module tb_cla_nibble_sub;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit rand_rdy = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int           acc;   // edge number of the accepting edge
   } exp_t;

   exp_t q[$];

   cla_nibble_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Plain-arithmetic reference: unsigned difference, unsigned compare, sign rule for overflow
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
      exp_t m;
      m.d   = x - y;
      m.br  = (x < y);
      m.ov  = (x[W-1] != y[W-1]) && (m.d[W-1] != x[W-1]);
      m.acc = acc;
      return m;
   endfunction

   // Scoreboard compare, every cycle away from the active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         chk("rst_in_ready",  32'(in_ready),  32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_diff",      32'(diff),      32'd0);
         chk("rst_borrow",    32'(borrow),    32'd0);
         chk("rst_ovf",       32'(ovf),       32'd0);
      end else begin
         chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
         chk("out_valid", 32'(out_valid),
             32'((q.size() != 0) && (cyc >= q[0].acc + NIB)));
         if (out_valid && q.size() != 0) begin
            chk("diff",   32'(diff),   32'(q[0].d));
            chk("borrow", 32'(borrow), 32'(q[0].br));
            chk("ovf",    32'(ovf),    32'(q[0].ov));
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(model(a, b, cyc + 1));
      end
   end

   // Advance to just after the next rising edge; optionally randomize out_ready
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present operands until accepted, then scramble a/b to prove they were sampled once
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      bit got;
      tick();
      a        = x;
      b        = y;
      in_valid = 1'b1;
      got      = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1;
         tick();
      end
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // Wait for out_valid (at a falling edge) and check against literal results
   task automatic wait_result(input string nm, input logic [W-1:0] d,
                              input logic br, input logic ov);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      if (!seen) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({nm, "_diff"},   32'(diff),   32'(d));
         chk({nm, "_borrow"}, 32'(borrow), 32'(br));
         chk({nm, "_ovf"},    32'(ovf),    32'(ov));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Test 1: basic, out_ready tied high
      out_ready = 1'b1;
      issue(16'h1234, 16'h0234);
      wait_result("t1", 16'h1000, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
      chk("t1_in_ready_back",  32'(in_ready),  32'd1);

      // Test 2: full-width borrow and a borrow rippling across nibbles
      issue(16'h0000, 16'h0001);
      wait_result("t2a", 16'hFFFF, 1'b1, 1'b0);
      issue(16'h1000, 16'h0001);
      wait_result("t2b", 16'h0FFF, 1'b0, 1'b0);

      // Test 3: signed overflow both directions, equal operands
      issue(16'h8000, 16'h0001);
      wait_result("t3a", 16'h7FFF, 1'b0, 1'b1);
      issue(16'h7FFF, 16'hFFFF);
      wait_result("t3b", 16'h8000, 1'b1, 1'b1);
      issue(16'h5A5A, 16'h5A5A);
      wait_result("t3c", 16'h0000, 1'b0, 1'b0);

      // Test 4: result stalled while a new request waits
      tick();
      out_ready = 1'b0;
      issue(16'h4321, 16'h1234);
      wait_result("t4a", 16'h30ED, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         in_valid = 1'b1;
         a        = 16'hFFFF;
         b        = 16'h0001;
         @(negedge clk);
         chk("t4_stall_in_ready",  32'(in_ready),  32'd0);
         chk("t4_stall_out_valid", 32'(out_valid), 32'd1);
         chk("t4_stall_diff",      32'(diff),      32'h30ED);
      end
      tick();
      out_ready = 1'b1;
      begin
         bit got;
         got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            tick();
         end
         in_valid = 1'b0;
         if (!got) chk("t4_accept_timeout", 32'd0, 32'd1);
      end
      wait_result("t4b", 16'hFFFE, 1'b0, 1'b0);

      // Test 5: asynchronous reset in the middle of a calculation
      issue(16'h0010, 16'h0020);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_in_ready",  32'(in_ready),  32'd1);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_diff",      32'(diff),      32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      issue(16'h0003, 16'h0002);
      wait_result("t5b", 16'h0001, 1'b0, 1'b0);

      // Test 6: random traffic with random stalls; scoreboard checks every cycle
      rand_rdy = 1;
      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] x, y;
         int sel;
         x   = W'($urandom);
         y   = W'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0) y = x;
         if (sel == 1) y = '0;
         if (sel == 2) x = '0;
         repeat ($urandom_range(0, 2)) tick();
         issue(x, y);
      end
      rand_rdy  = 0;
      out_ready = 1'b1;
      begin
         bit drained;
         drained = 0;
         for (int i = 0; i < 200 && !drained; i++) begin
            @(negedge clk);
            if (q.size() == 0) drained = 1;
         end
         if (!drained) chk("drain_timeout", 32'd0, 32'd1);
      end
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
